// File: rtl/dpe_arb_pkg.sv
// ---------------------------------------------------------------------------
// dpe_arb_pkg
//   Shared types and helpers for the DPE ingress arbiter and its round-robin
//   picker.
//
//   arb_state_t : arbiter FSM states
//                   IDLE - no grant held, arbitration runs every cycle
//                   PASS - one port granted, its packet streams through
//   port_w(n)   : width of a port index for n ports, never less than 1 bit
// ---------------------------------------------------------------------------
package dpe_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_t;

    function automatic int unsigned port_w(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage : dpe_arb_pkg

// File: rtl/dpe_rr_pick.sv
// ---------------------------------------------------------------------------
// dpe_rr_pick
//   Combinational round-robin pick. Scans req starting at last+1 and wrapping
//   modulo NUM_PORTS. Returns the first set bit found.
//
//   Parameters
//     NUM_PORTS : number of requesters (>= 2)
//   Ports
//     req  in  [NUM_PORTS]  request vector
//     last in  [PORT_W]     index of the previous winner (highest priority
//                           goes to last+1)
//     any  out              at least one request present
//     idx  out [PORT_W]     winning index (0 when any=0)
// ---------------------------------------------------------------------------
module dpe_rr_pick
    import dpe_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 5,
    localparam int unsigned PORT_W    = port_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last,
    output logic                 any,
    output logic [PORT_W-1:0]    idx
);

    logic [2*NUM_PORTS-1:0] dbl;
    logic [2*NUM_PORTS-1:0] shifted;
    logic [NUM_PORTS-1:0]   rot;
    int unsigned            start;
    int unsigned            hit;
    logic                   found;

    // Rotate by concatenating req with itself and shifting. Bit 0 of rot is
    // then the highest-priority port, so a plain lowest-set-bit search gives
    // the round-robin winner as an offset from start.
    always_comb begin
        start   = (32'(last) + 1) % NUM_PORTS;
        dbl     = {req, req};
        shifted = dbl >> start;
        rot     = shifted[NUM_PORTS-1:0];
        found   = 1'b0;
        hit     = 0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                hit   = j;
            end
        end
        any = found;
        idx = found ? PORT_W'((start + hit) % NUM_PORTS) : '0;
    end

endmodule : dpe_rr_pick

// File: rtl/dpe_ingress_arb.sv
// ---------------------------------------------------------------------------
// dpe_ingress_arb
//   Packet-granular NUM_PORTS-way round-robin arbiter. It merges the ingress
//   AXI-Stream sources (CPU FIFO and MAC RX FIFOs) into the single stream
//   consumed by the DPE. A grant is held for a whole packet. Each new packet
//   costs one idle arbitration cycle.
//
//   Parameters
//     NUM_PORTS : number of ingress streams (>= 2)
//     DATA_W    : tdata width, KEEP_W = DATA_W/8
//     CNT_W     : width of each saturating packet counter
//   Ports
//     clk, rst         sys_clk; synchronous active-high reset
//     pause            hold off new grants; the current packet completes
//     is_idle          no packet granted
//     port_en          per-port grant enable (checked at arbitration only)
//     cnt_clr          synchronous clear of all packet counters
//     s_t*             ingress streams, port i in slice i
//     m_t*             merged stream; m_tid = source port of current packet
//     pkt_cnt          packets forwarded per port, port i in slice i
// ---------------------------------------------------------------------------
module dpe_ingress_arb
    import dpe_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 5,
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned CNT_W     = 32,
    localparam int unsigned KEEP_W    = DATA_W / 8,
    localparam int unsigned PORT_W    = port_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pause,
    output logic                        is_idle,
    input  logic [NUM_PORTS-1:0]        port_en,
    input  logic                        cnt_clr,
    input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0] s_tkeep,
    input  logic [NUM_PORTS-1:0]        s_tvalid,
    input  logic [NUM_PORTS-1:0]        s_tlast,
    output logic [NUM_PORTS-1:0]        s_tready,
    output logic [DATA_W-1:0]           m_tdata,
    output logic [KEEP_W-1:0]           m_tkeep,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    output logic [PORT_W-1:0]           m_tid,
    input  logic                        m_tready,
    output logic [NUM_PORTS*CNT_W-1:0]  pkt_cnt
);

    arb_state_t           state_q, state_d;
    logic [PORT_W-1:0]    grant_q, grant_d;
    logic [PORT_W-1:0]    last_q,  last_d;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] inc;
    logic                 pick_any;
    logic [PORT_W-1:0]    pick_idx;

    logic [DATA_W-1:0]    tdata_a [NUM_PORTS];
    logic [KEEP_W-1:0]    tkeep_a [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q   [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign tdata_a[i]                 = s_tdata[i*DATA_W +: DATA_W];
        assign tkeep_a[i]                 = s_tkeep[i*KEEP_W +: KEEP_W];
        assign pkt_cnt[i*CNT_W +: CNT_W]  = cnt_q[i];
    end

    assign req = s_tvalid & port_en;

    dpe_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next state and the pass-through mux. port_en and pause only gate the
    // IDLE pick, so a granted packet always runs to its tlast.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        inc      = '0;
        s_tready = '0;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!pause && pick_any) begin
                    grant_d = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                m_tdata           = tdata_a[grant_q];
                m_tkeep           = tkeep_a[grant_q];
                m_tvalid          = s_tvalid[grant_q];
                m_tlast           = s_tlast[grant_q];
                s_tready[grant_q] = m_tready;
                if (m_tvalid && m_tready && m_tlast) begin
                    last_d       = grant_q;
                    inc[grant_q] = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating packet counters; a clear takes priority over a same-cycle
    // increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (inc[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign is_idle = (state_q == IDLE);
    assign m_tid   = grant_q;

endmodule : dpe_ingress_arb
